// File: rtl/work_dispatcher_rr_if.sv
// Handshake bundle for work_dispatcher_rr.
//   in_data/in_valid/in_ready : single upstream work-item channel
//   out_data                  : NUM_PE lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready       : per-lane downstream handshake
// NUM_PE and DATA_WIDTH must match the dispatcher instance it connects to.
// modport slave is the dispatcher's view; modport master is the driver's view.
interface work_dispatcher_rr_if #(
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]        in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_PE*DATA_WIDTH-1:0] out_data;
  logic [NUM_PE-1:0]            out_valid;
  logic [NUM_PE-1:0]            out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/work_dispatcher_rr.sv
// Round-robin dispatcher: distributes a single stream of work items across
// NUM_PE output lanes, each holding one registered slot.
// Ports:
//   clk            : clock, all state on rising edge
//   rst_n          : asynchronous active-low reset
//   skip_mode      : 0 = strict round-robin, 1 = skip lanes that cannot accept
//   flush          : synchronous clear of slots, pointer and counter
//   bus            : work_dispatcher_rr_if.slave (input channel + per-lane outputs)
//   dispatch_count : items accepted since reset or flush (wraps)
//   busy           : OR of all lane valids
module work_dispatcher_rr #(
  parameter int unsigned NUM_PE         = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PE_INDEX_WIDTH = 2,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 skip_mode,
  input  logic                 flush,
  work_dispatcher_rr_if.slave  bus,
  output logic [CNT_WIDTH-1:0] dispatch_count,
  output logic                 busy
);

  localparam logic [PE_INDEX_WIDTH-1:0] LAST_PE = PE_INDEX_WIDTH'(NUM_PE - 1);

  logic [NUM_PE-1:0]                 full_q, full_d;
  logic [NUM_PE-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [PE_INDEX_WIDTH-1:0]         ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]              cnt_q, cnt_d;

  logic [NUM_PE-1:0]         lane_free;
  logic [PE_INDEX_WIDTH-1:0] target;
  logic                      found;
  int unsigned               scan_idx;
  logic                      accept;

  // A lane can take a new item if it is empty or is draining this cycle.
  assign lane_free = ~full_q | bus.out_ready;

  // Target lane: the pointer in strict mode; otherwise the first free lane
  // scanning cyclically from the pointer.
  always_comb begin
    target   = ptr_q;
    found    = 1'b0;
    scan_idx = 0;
    if (skip_mode) begin
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        scan_idx = (32'(ptr_q) + i) % NUM_PE;
        if (!found && lane_free[PE_INDEX_WIDTH'(scan_idx)]) begin
          target = PE_INDEX_WIDTH'(scan_idx);
          found  = 1'b1;
        end
      end
    end
  end

  assign bus.in_ready = !flush && (skip_mode ? |lane_free : lane_free[ptr_q]);
  assign accept       = bus.in_valid && bus.in_ready;

  // Drain first, then refill: a same-cycle drain and refill of one lane
  // leaves it full with the new item.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      full_d = '0;
      data_d = '0;
      ptr_d  = '0;
      cnt_d  = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        if (full_q[i] && bus.out_ready[i]) begin
          full_d[i] = 1'b0;
          data_d[i] = '0;
        end
      end
      if (accept) begin
        full_d[target] = 1'b1;
        data_d[target] = bus.in_data;
        ptr_d          = (target == LAST_PE) ? '0 : target + 1'b1;
        cnt_d          = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      data_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Empty lanes present zero data regardless of slot contents.
  always_comb begin
    bus.out_data = '0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      bus.out_data[i*DATA_WIDTH +: DATA_WIDTH] = full_q[i] ? data_q[i] : '0;
    end
  end

  assign bus.out_valid   = full_q;
  assign busy            = |full_q;
  assign dispatch_count  = cnt_q;

endmodule

// File: tb/tb_work_dispatcher_rr.sv
// Self-checking bench for work_dispatcher_rr (NUM_PE=4, DATA_WIDTH=8, CNT_WIDTH=4).
// Every cycle is checked against a lane-array reference model; directed
// sequences add fixed expected values for the corner cases.
module tb_work_dispatcher_rr;
  localparam int NPE = 4;
  localparam int DW  = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          skip_mode;
  logic          flush;
  logic [CW-1:0] dispatch_count;
  logic          busy;

  work_dispatcher_rr_if #(.NUM_PE(NPE), .DATA_WIDTH(DW)) bus ();

  work_dispatcher_rr #(
    .NUM_PE(NPE), .DATA_WIDTH(DW), .PE_INDEX_WIDTH(2), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .skip_mode(skip_mode), .flush(flush),
    .bus(bus.slave), .dispatch_count(dispatch_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          mfull[NPE];
  logic [DW-1:0] mdata[NPE];
  int          mptr;
  int          mcnt;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NPE; i++) begin
      mfull[i] = 1'b0;
      mdata[i] = '0;
    end
    mptr = 0;
    mcnt = 0;
  endfunction

  function automatic bit m_free(input int i, input logic [NPE-1:0] ordy);
    return !mfull[i] || ordy[i];
  endfunction

  function automatic int m_target(input bit sk, input logic [NPE-1:0] ordy);
    if (!sk) return mptr;
    for (int k = 0; k < NPE; k++)
      if (m_free((mptr + k) % NPE, ordy)) return (mptr + k) % NPE;
    return mptr;
  endfunction

  function automatic bit m_ready(input bit sk, input bit fl, input logic [NPE-1:0] ordy);
    bit any = 1'b0;
    if (fl) return 1'b0;
    if (!sk) return m_free(mptr, ordy);
    for (int k = 0; k < NPE; k++) any |= m_free(k, ordy);
    return any;
  endfunction

  function automatic logic [NPE-1:0] m_valid();
    logic [NPE-1:0] v = '0;
    for (int i = 0; i < NPE; i++) v[i] = mfull[i];
    return v;
  endfunction

  function automatic logic [NPE*DW-1:0] m_out_data();
    logic [NPE*DW-1:0] d = '0;
    for (int i = 0; i < NPE; i++) if (mfull[i]) d[i*DW +: DW] = mdata[i];
    return d;
  endfunction

  function automatic void m_step(input bit sk, input bit fl, input bit vld,
                                 input logic [DW-1:0] din, input logic [NPE-1:0] ordy);
    bit acc = vld && m_ready(sk, fl, ordy);
    int t   = m_target(sk, ordy);
    if (fl) begin
      m_reset();
    end else begin
      for (int i = 0; i < NPE; i++)
        if (mfull[i] && ordy[i]) begin
          mfull[i] = 1'b0;
          mdata[i] = '0;
        end
      if (acc) begin
        mfull[t] = 1'b1;
        mdata[t] = din;
        mptr     = (t + 1) % NPE;
        mcnt     = (mcnt + 1) % (1 << CW);
      end
    end
  endfunction

  function automatic logic [DW-1:0] lane(input int i);
    return bus.out_data[i*DW +: DW];
  endfunction

  // One clock: apply inputs, check all outputs against the model mid-cycle,
  // advance the model, and return just after the rising edge.
  task automatic drive(input bit sk, input bit fl, input bit vld,
                       input logic [DW-1:0] din, input logic [NPE-1:0] ordy,
                       output logic rdy);
    skip_mode     = sk;
    flush         = fl;
    bus.in_valid  = vld;
    bus.in_data   = din;
    bus.out_ready = ordy;
    @(negedge clk);
    rdy = bus.in_ready;
    chk("in_ready", 64'(bus.in_ready), 64'(m_ready(sk, fl, ordy)));
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid()));
    chk("out_data", 64'(bus.out_data), 64'(m_out_data()));
    chk("dispatch_count", 64'(dispatch_count), 64'(mcnt));
    chk("busy", 64'(busy), 64'(|m_valid()));
    m_step(sk, fl, vld, din, ordy);
    @(posedge clk);
    #1;
  endtask

  // ---------------- strict round-robin vector table ----------------
  typedef struct {
    logic [DW-1:0]  din;
    int             lane;
    logic [NPE-1:0] exp_valid;
    int             exp_cnt;
  } rr_vec_t;

  rr_vec_t rr_tab[8];

  initial begin
    logic r;

    rr_tab[0] = '{8'hA0, 0, 4'b0001, 1};
    rr_tab[1] = '{8'hA1, 1, 4'b0010, 2};
    rr_tab[2] = '{8'hA2, 2, 4'b0100, 3};
    rr_tab[3] = '{8'hA3, 3, 4'b1000, 4};
    rr_tab[4] = '{8'hA4, 0, 4'b0001, 5};
    rr_tab[5] = '{8'hA5, 1, 4'b0010, 6};
    rr_tab[6] = '{8'hA6, 2, 4'b0100, 7};
    rr_tab[7] = '{8'hA7, 3, 4'b1000, 8};

    rst_n         = 1'b0;
    skip_mode     = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    m_reset();

    #2;
    chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_out_data", 64'(bus.out_data), 64'(0));
    chk("reset_count", 64'(dispatch_count), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 64'(bus.in_ready), 64'(1));

    // Strict RR: A0..A7 back to back, all lanes ready.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 1'b1, rr_tab[k].din, 4'hF, r);
      chk($sformatf("rr_ready[%0d]", k), 64'(r), 64'(1));
      chk($sformatf("rr_valid[%0d]", k), 64'(bus.out_valid), 64'(rr_tab[k].exp_valid));
      chk($sformatf("rr_data[%0d]", k), 64'(lane(rr_tab[k].lane)), 64'(rr_tab[k].din));
      chk($sformatf("rr_cnt[%0d]", k), 64'(dispatch_count), 64'(rr_tab[k].exp_cnt));
    end

    // Strict stall on lane 1 with ptr=1, then release.
    drive(1'b0, 1'b1, 1'b0, 8'h00, 4'hF, r);
    drive(1'b0, 1'b0, 1'b1, 8'h11, 4'hF, r);
    drive(1'b0, 1'b0, 1'b1, 8'h12, 4'hF, r);
    drive(1'b0, 1'b0, 1'b1, 8'h13, 4'b1101, r);
    drive(1'b0, 1'b0, 1'b1, 8'h14, 4'b1101, r);
    drive(1'b0, 1'b0, 1'b1, 8'h15, 4'b1101, r);
    drive(1'b0, 1'b0, 1'b1, 8'h99, 4'b1101, r);
    chk("stall_ready", 64'(r), 64'(0));
    chk("stall_hold", 64'(lane(1)), 64'(8'h12));
    drive(1'b0, 1'b0, 1'b1, 8'h77, 4'b1111, r);
    chk("stall_release_ready", 64'(r), 64'(1));
    chk("stall_release_data", 64'(lane(1)), 64'(8'h77));
    chk("stall_release_valid", 64'(bus.out_valid), 64'(4'b0010));

    // Skip mode: lanes 1,2 stalled, ptr=1 -> lane 3, then lane 0.
    drive(1'b0, 1'b1, 1'b0, 8'h00, 4'hF, r);
    drive(1'b0, 1'b0, 1'b1, 8'h21, 4'b1001, r);
    drive(1'b0, 1'b0, 1'b1, 8'h22, 4'b1001, r);
    drive(1'b0, 1'b0, 1'b1, 8'h23, 4'b1001, r);
    drive(1'b0, 1'b0, 1'b1, 8'h24, 4'b1001, r);
    drive(1'b0, 1'b0, 1'b1, 8'h25, 4'b1001, r);
    drive(1'b1, 1'b0, 1'b1, 8'h31, 4'b1001, r);
    chk("skip_ready", 64'(r), 64'(1));
    chk("skip_lane3", 64'(lane(3)), 64'(8'h31));
    chk("skip_valid", 64'(bus.out_valid), 64'(4'b1110));
    drive(1'b1, 1'b0, 1'b1, 8'h32, 4'b0000, r);
    chk("skip_lane0", 64'(lane(0)), 64'(8'h32));
    chk("skip_valid_full", 64'(bus.out_valid), 64'(4'b1111));

    // All busy, then release only lane 2.
    drive(1'b1, 1'b0, 1'b1, 8'h40, 4'b0000, r);
    chk("allbusy_ready", 64'(r), 64'(0));
    drive(1'b1, 1'b0, 1'b1, 8'h41, 4'b0100, r);
    chk("release2_ready", 64'(r), 64'(1));
    chk("release2_data", 64'(lane(2)), 64'(8'h41));
    chk("release2_valid", 64'(bus.out_valid), 64'(4'b1111));

    // Flush with lanes 0-2 full and count 5.
    drive(1'b0, 1'b1, 1'b0, 8'h00, 4'hF, r);
    drive(1'b0, 1'b0, 1'b1, 8'h51, 4'hF, r);
    drive(1'b0, 1'b0, 1'b1, 8'h52, 4'hF, r);
    drive(1'b0, 1'b0, 1'b1, 8'h53, 4'h0, r);
    drive(1'b0, 1'b0, 1'b1, 8'h54, 4'h0, r);
    drive(1'b0, 1'b0, 1'b1, 8'h55, 4'b1000, r);
    chk("preflush_valid", 64'(bus.out_valid), 64'(4'b0111));
    chk("preflush_cnt", 64'(dispatch_count), 64'(5));
    drive(1'b0, 1'b1, 1'b1, 8'h66, 4'hF, r);
    chk("flush_ready", 64'(r), 64'(0));
    chk("flush_valid", 64'(bus.out_valid), 64'(0));
    chk("flush_cnt", 64'(dispatch_count), 64'(0));
    chk("flush_busy", 64'(busy), 64'(0));
    drive(1'b0, 1'b0, 1'b1, 8'h67, 4'h0, r);
    chk("postflush_lane0", 64'(lane(0)), 64'(8'h67));
    chk("postflush_valid", 64'(bus.out_valid), 64'(4'b0001));

    // Counter wrap: 17 accepts on a 4-bit counter.
    drive(1'b0, 1'b1, 1'b0, 8'h00, 4'hF, r);
    for (int k = 0; k < 17; k++) drive(1'b0, 1'b0, 1'b1, DW'(k), 4'hF, r);
    chk("wrap_cnt", 64'(dispatch_count), 64'(1));

    // Reset asserted mid-burst, away from any clock edge.
    skip_mode     = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hEE;
    bus.out_ready = 4'h0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", 64'(bus.out_valid), 64'(0));
    chk("midreset_data", 64'(bus.out_data), 64'(0));
    chk("midreset_cnt", 64'(dispatch_count), 64'(0));
    chk("midreset_busy", 64'(busy), 64'(0));
    m_reset();
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("ready_after_midreset", 64'(bus.in_ready), 64'(1));

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0),
            DW'($urandom),
            NPE'($urandom),
            r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/work_dispatcher_rr.md
WORK_DISPATCHER_RR -- requirements
Module: work_dispatcher_rr

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, number of PE output lanes (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of one work item.
REQ-003 SHALL have parameter PE_INDEX_WIDTH, default 2, pointer width, equal to $clog2(NUM_PE).
REQ-004 SHALL have parameter CNT_WIDTH, default 32, width of dispatch counter.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port skip_mode, input, 1: 0 = strict round-robin; 1 = skip lanes that cannot accept.
REQ-008 SHALL have port flush, input, 1, synchronous clear of all lane buffers and the pointer.
REQ-009 SHALL have port in_data, input, DATA_WIDTH, the incoming work item.
REQ-010 SHALL have port in_valid, input, 1, work item present.
REQ-011 SHALL have port in_ready, output, 1, item accepted when in_valid && in_ready.
REQ-012 SHALL have port out_data, output, NUM_PE*DATA_WIDTH, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port out_valid, output, NUM_PE, per-lane valid.
REQ-014 SHALL have port out_ready, input, NUM_PE, per-lane ready.
REQ-015 SHALL have port dispatch_count, output, CNT_WIDTH, items accepted since reset or flush.
REQ-016 SHALL have port busy, output, 1, OR of out_valid.

Function
REQ-017 SHALL hold, per lane, one registered slot (full flag and data); out_valid[i] = full[i]; out_data lane i = slot data.
REQ-018 SHALL drive out_data lane i to zero whenever full[i] = 0.
REQ-019 SHALL treat lane i as free when !full[i] || out_ready[i]; the combinational path out_ready -> in_ready is permitted.
REQ-020 SHALL, with skip_mode=0, set target to ptr; in_ready = free[ptr].
REQ-021 SHALL, with skip_mode=1, set target to the first free lane searching ptr, ptr+1, ... cyclically with wrap at NUM_PE-1 -> 0; in_ready = 1 if any lane is free.
REQ-022 SHALL, on accept, load in_data into the target slot, set full[target], and set ptr <= target+1, wrapping NUM_PE-1 -> 0.
REQ-023 SHALL, on out_valid[i] && out_ready[i] with no refill of lane i that cycle, clear full[i] and the slot data.
REQ-024 SHALL, on simultaneous drain and refill of the same lane, keep full[i]=1 and hold the new data.
REQ-025 SHALL leave ptr unchanged when no item is accepted, including while in_valid=0.
REQ-026 SHALL, on accept, increment dispatch_count by 1, wrapping modulo 2^CNT_WIDTH.
REQ-027 SHALL, when flush=1, hold in_ready=0, clear all slots, ptr and dispatch_count at the next edge, ignore that cycle's drain handshakes, and drop any pending items.
REQ-028 SHALL have latency of 1 cycle from input acceptance to out_valid of the target lane; sustained throughput of 1 item per cycle when the target lanes drain.
REQ-029 SHALL, when skip_mode changes, apply the new mode in the same cycle, with the pointer continuing from its current value.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force ptr=0, all full=0, out_valid=0, out_data=0, dispatch_count=0, busy=0.
REQ-031 SHALL drop slot contents if reset is asserted mid-operation; no item survives reset.
REQ-032 SHALL keep in_ready=1 after reset release with skip_mode=0, since lane 0 is empty.

Verification
REQ-033 SHALL cover strict RR: NUM_PE=4, all out_ready=1, items 0xA0..0xA7 on consecutive cycles -> lanes 0,1,2,3,0,1,2,3 one cycle later; dispatch_count=8.
REQ-034 SHALL cover a strict stall: skip_mode=0, lane 1 full with out_ready[1]=0, ptr=1 -> in_ready=0, ptr stays 1; raise out_ready[1] -> accept in the same cycle.
REQ-035 SHALL cover skip: skip_mode=1, lanes 1,2 full and stalled, ptr=1 -> item lands on lane 3, ptr=0; next item lands on lane 0.
REQ-036 SHALL cover all-busy: skip_mode=1, all lanes full with out_ready=0 -> in_ready=0; release lane 2 only -> next item to lane 2.
REQ-037 SHALL cover flush: lanes 0-2 full, dispatch_count=5, flush=1 for one cycle -> out_valid=0, ptr=0, count=0, in_ready=0 during the flush cycle.
REQ-038 SHALL cover wrap and reset: CNT_WIDTH=4 with 17 accepts -> count=1; assert rst_n=0 mid-burst -> all outputs 0 immediately.
